fetch_stage: RTL and testbench

//  IF stage of the 5-stage pipeline: owns the architectural fetch PC, issues instruction-bus

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: owns the fetch PC, issues instruction-bus requests, buffers the instruction.
// At most one bus request is outstanding; redirects squash buffered or in-flight fetches.
module fetch_stage #(
  parameter int               XLEN     = 64,
  parameter int               ILEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_addr_ok,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            out_exc,
  output logic [XLEN-1:0] pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            exc_q;
  logic            misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  assign ireq_valid = (state_q == S_REQ) && reset && !misaligned;
  assign ireq_addr  = pc_q;
  assign pc         = pc_q;
  // A redirect in HOLD kills the buffered instruction in the same cycle.
  assign out_valid  = (state_q == S_HOLD) && !redirect_valid;
  assign out_pc     = pc_q;
  assign out_instr  = instr_q;
  assign out_exc    = exc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (misaligned) begin
            exc_q   <= 1'b1;
            instr_q <= '0;
            state_q <= S_HOLD;
          end else if (redirect_valid) begin
            pc_q <= redirect_pc;
          end else if (iresp_addr_ok && iresp_data_ok) begin
            instr_q <= iresp_data;
            exc_q   <= 1'b0;
            state_q <= S_HOLD;
          end else if (iresp_addr_ok) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= iresp_data_ok ? S_REQ : S_DROP;
          end else if (iresp_data_ok) begin
            instr_q <= iresp_data;
            exc_q   <= 1'b0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            exc_q   <= 1'b0;
            state_q <= S_REQ;
          end else if (!stall) begin
            pc_q    <= pc_q + XLEN'(4);
            exc_q   <= 1'b0;
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          // The stale response must drain before a new request may issue.
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end
          if (iresp_data_ok) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scenario bench for fetch_stage with an expected-output scoreboard.
module tb_fetch_stage;

  localparam logic [63:0] RST = 64'h8000_0000;

  typedef struct packed {
    logic        exc;
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;
  logic [63:0] pc;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc),
    .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic idle();
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'hDEAD_BEEF;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
  endtask

  function automatic exp_t sb_pop();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic push(input logic exc, input logic [63:0] p, input logic [31:0] ins);
    exp_t t;
    t = '{exc: exc, pc: p, instr: ins};
    sb.push_back(t);
  endtask

  task automatic test_reset();
    reset = 1'b0; idle();
    @(negedge clk); #1;
    n_cmp++; if (ireq_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ireq_valid got %b want 0", ireq_valid); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
    n_cmp++; if (out_exc !== 1'b0) begin n_bad++; $display("FAIL rst_out_exc got %b want 0", out_exc); end
    n_cmp++; if (out_pc !== RST || pc !== RST) begin n_bad++; $display("FAIL rst_pc got %h/%h want %h", out_pc, pc, RST); end
  endtask

  task automatic test_first_fetch();
    @(negedge clk); reset = 1'b1; iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
    push(1'b0, RST, 32'h0000_0013); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST) begin n_bad++; $display("FAIL t1_req got %b/%h want 1/%h", ireq_valid, ireq_addr, RST); end
    @(negedge clk); idle(); #1;
    e = sb_pop();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL t1_out_valid got %b want 1", out_valid); end
    n_cmp++; if ({out_exc, out_pc, out_instr} !== e) begin n_bad++; $display("FAIL t1_out got %h want %h", {out_exc, out_pc, out_instr}, e); end
    n_cmp++; if (ireq_valid !== 1'b0) begin n_bad++; $display("FAIL t1_hold_noreq got %b want 0", ireq_valid); end
    @(negedge clk); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'd4) begin n_bad++; $display("FAIL t1_next_req got %b/%h want 1/%h", ireq_valid, ireq_addr, RST + 64'd4); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk); iresp_addr_ok = 1'b1; #1;
    n_cmp++; if (ireq_addr !== RST + 64'd4) begin n_bad++; $display("FAIL t2_req got %h want %h", ireq_addr, RST + 64'd4); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); #1;
      n_cmp++; if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL t2_wait got %b/%b want 0/0", ireq_valid, out_valid); end
    end
    @(negedge clk); iresp_data_ok = 1'b1; iresp_data = d; push(1'b0, RST + 64'd4, d); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t2_data_cycle got %b want 0", out_valid); end
    @(negedge clk); idle(); stall = 1'b1; #1;
    e = sb_pop();
    n_cmp++; if (out_valid !== 1'b1 || {out_exc, out_pc, out_instr} !== e) begin n_bad++; $display("FAIL t2_out got %b/%h want 1/%h", out_valid, {out_exc, out_pc, out_instr}, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || ireq_valid !== 1'b0 || {out_exc, out_pc, out_instr} !== e) begin n_bad++; $display("FAIL t2_stall_hold got %b/%b/%h want 1/0/%h", out_valid, ireq_valid, {out_exc, out_pc, out_instr}, e); end
    end
    @(negedge clk); stall = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL t2_release got %b want 1", out_valid); end
    @(negedge clk); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'd8) begin n_bad++; $display("FAIL t2_next_req got %b/%h want 1/%h", ireq_valid, ireq_addr, RST + 64'd8); end
  endtask

  task automatic test_redirect_wait();
    @(negedge clk); iresp_addr_ok = 1'b1; #1;
    @(negedge clk); idle(); redirect_valid = 1'b1; redirect_pc = RST + 64'h100; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t3_redir got %b want 0", out_valid); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (out_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_bad++; $display("FAIL t3_drop got %b/%b want 0/0", out_valid, ireq_valid); end
    @(negedge clk); iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_0001; #1;
    n_cmp++; if (out_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_bad++; $display("FAIL t3_stale got %b/%b want 0/0", out_valid, ireq_valid); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h100 || out_valid !== 1'b0) begin n_bad++; $display("FAIL t3_refetch got %b/%h/%b want 1/%h/0", ireq_valid, ireq_addr, out_valid, RST + 64'h100); end
  endtask

  task automatic test_redirect_coincident();
    @(negedge clk); iresp_addr_ok = 1'b1; #1;
    @(negedge clk); idle(); redirect_valid = 1'b1; redirect_pc = RST + 64'h200; iresp_data_ok = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t4_coinc got %b want 0", out_valid); end
    @(negedge clk); idle(); iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h1111_2222; #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h200) begin n_bad++; $display("FAIL t4_req got %b/%h want 1/%h", ireq_valid, ireq_addr, RST + 64'h200); end
    @(negedge clk); idle(); redirect_valid = 1'b1; redirect_pc = RST + 64'h300; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t4_hold_redir got %b want 0", out_valid); end
    @(negedge clk); idle(); iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = RST + 64'h400; #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h300) begin n_bad++; $display("FAIL t4_req2 got %b/%h want 1/%h", ireq_valid, ireq_addr, RST + 64'h300); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h400 || out_valid !== 1'b0) begin n_bad++; $display("FAIL t4_redir_wins got %b/%h/%b want 1/%h/0", ireq_valid, ireq_addr, out_valid, RST + 64'h400); end
  endtask

  task automatic test_misaligned();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = RST + 64'h102; #1;
    @(negedge clk); idle(); push(1'b1, RST + 64'h102, 32'h0); #1;
    n_cmp++; if (ireq_valid !== 1'b0) begin n_bad++; $display("FAIL t5_noreq got %b want 0", ireq_valid); end
    @(negedge clk); stall = 1'b1; #1;
    e = sb_pop();
    n_cmp++; if (out_valid !== 1'b1 || {out_exc, out_pc, out_instr} !== e) begin n_bad++; $display("FAIL t5_exc got %b/%h want 1/%h", out_valid, {out_exc, out_pc, out_instr}, e); end
    @(negedge clk); stall = 1'b0; redirect_valid = 1'b1; redirect_pc = RST + 64'h500; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t5_redir got %b want 0", out_valid); end
    @(negedge clk); idle(); iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = d; push(1'b0, RST + 64'h500, d); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h500) begin n_bad++; $display("FAIL t5_req got %b/%h want 1/%h", ireq_valid, ireq_addr, RST + 64'h500); end
    @(negedge clk); idle(); #1;
    e = sb_pop();
    n_cmp++; if (out_valid !== 1'b1 || {out_exc, out_pc, out_instr} !== e) begin n_bad++; $display("FAIL t5_clear got %b/%h want 1/%h", out_valid, {out_exc, out_pc, out_instr}, e); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    @(negedge clk); idle(); iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = d; push(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, d); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL t6_req got %b/%h want 1/fffffffffffffffc", ireq_valid, ireq_addr); end
    @(negedge clk); idle(); #1;
    e = sb_pop();
    n_cmp++; if (out_valid !== 1'b1 || {out_exc, out_pc, out_instr} !== e) begin n_bad++; $display("FAIL t6_out got %b/%h want 1/%h", out_valid, {out_exc, out_pc, out_instr}, e); end
    @(negedge clk); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0 || pc !== 64'h0) begin n_bad++; $display("FAIL t6_wrap got %b/%h/%h want 1/0/0", ireq_valid, ireq_addr, pc); end
  endtask

  task automatic test_drop_redirect();
    @(negedge clk); iresp_addr_ok = 1'b1; #1;
    @(negedge clk); idle(); redirect_valid = 1'b1; redirect_pc = RST + 64'h600; #1;
    @(negedge clk); idle(); redirect_valid = 1'b1; redirect_pc = RST + 64'h700; #1;
    n_cmp++; if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drop_redir got %b/%b want 0/0", ireq_valid, out_valid); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (ireq_valid !== 1'b0 || pc !== RST + 64'h700) begin n_bad++; $display("FAIL drop_hold got %b/%h want 0/%h", ireq_valid, pc, RST + 64'h700); end
    @(negedge clk); iresp_data_ok = 1'b1; #1;
    @(negedge clk); idle(); #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'h700) begin n_bad++; $display("FAIL drop_refetch got %b/%h want 1/%h", ireq_valid, ireq_addr, RST + 64'h700); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [63:0] a;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      a = RST + 64'h700 + 64'(4 * i);
      @(negedge clk); idle(); iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = d; push(1'b0, a, d); #1;
      n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== a) begin n_bad++; $display("FAIL b2b_req%0d got %b/%h want 1/%h", i, ireq_valid, ireq_addr, a); end
      @(negedge clk); idle(); #1;
      e = sb_pop();
      n_cmp++; if (out_valid !== 1'b1 || {out_exc, out_pc, out_instr} !== e) begin n_bad++; $display("FAIL b2b_out%0d got %b/%h want 1/%h", i, out_valid, {out_exc, out_pc, out_instr}, e); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); iresp_addr_ok = 1'b1; #1;
    @(negedge clk); idle(); #1;
    n_cmp++; if (ireq_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_wait got %b want 0", ireq_valid); end
    #2 reset = 1'b0; #1;
    n_cmp++; if (ireq_valid !== 1'b0 || pc !== RST || out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_async got %b/%h/%b want 0/%h/0", ireq_valid, pc, out_valid, RST); end
    @(negedge clk); reset = 1'b1; #1;
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RST) begin n_bad++; $display("FAIL rmid_release got %b/%h want 1/%h", ireq_valid, ireq_addr, RST); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_coincident();
    test_misaligned();
    test_wrap();
    test_drop_redirect();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
